// File: rtl/minimac3_slotctl.sv
// Two-slot RX buffer ownership tracker with an in-order completion queue,
// plus a single-frame TX handshake FSM with a timeout watchdog.
module minimac3_slotctl #(
   parameter logic [15:0] TX_TIMEOUT = 16'd50000
) (
   input  logic        sys_clk,
   input  logic        sys_rst,
   input  logic [1:0]  arm,
   output logic [1:0]  rx_ready,
   input  logic [1:0]  rx_done,
   input  logic [10:0] rx_count_0,
   input  logic [10:0] rx_count_1,
   output logic        rx_avail,
   output logic        rx_slot,
   output logic [10:0] rx_len,
   input  logic        rx_pop,
   output logic [1:0]  slot_state_0,
   output logic [1:0]  slot_state_1,
   output logic        rx_err,
   input  logic        tx_req,
   input  logic [10:0] tx_len,
   output logic        tx_start,
   output logic [10:0] tx_count,
   input  logic        tx_done,
   output logic        tx_busy,
   output logic        tx_timeout,
   output logic        irq
);

   localparam int unsigned LEN_W = 11;
   localparam int unsigned TMR_W = 16;

   typedef enum logic [1:0] {
      SLOT_IDLE  = 2'b00,
      SLOT_ARMED = 2'b01,
      SLOT_FULL  = 2'b10
   } slot_t;

   typedef enum logic [1:0] {
      TX_IDLE  = 2'b00,
      TX_START = 2'b01,
      TX_WAIT  = 2'b10
   } tx_t;

   logic [1:0]            idle;
   logic [1:0]            armed;
   logic [1:0]            push;
   logic [1:0][1:0]       st_v;
   logic [1:0][LEN_W-1:0] cnt_in;
   logic [1:0][LEN_W-1:0] len_nx;

   // Completion FIFO: two slot indices, head in q0
   logic [1:0] fcnt;
   logic       q0;
   logic       q1;
   logic [1:0] fcnt_nx;
   logic       q0_nx;
   logic       q1_nx;
   logic       pop_ok;
   logic       avail_nx;
   logic [LEN_W-1:0] len_head_nx;

   assign cnt_in = {rx_count_1, rx_count_0};
   assign pop_ok = rx_pop & (fcnt != 2'd0);
   assign push   = rx_done & armed;

   for (genvar g = 0; g < 2; g++) begin : g_slot
      slot_t            st;
      logic [LEN_W-1:0] len;

      assign idle[g]   = (st == SLOT_IDLE);
      assign armed[g]  = (st == SLOT_ARMED);
      assign st_v[g]   = st;
      assign len_nx[g] = push[g] ? cnt_in[g] : len;

      // A slot leaves FULL only when it is the head being popped
      always_ff @(posedge sys_clk or posedge sys_rst) begin
         if (sys_rst) begin
            st  <= SLOT_IDLE;
            len <= '0;
         end else begin
            len <= len_nx[g];
            case (st)
               SLOT_IDLE:  if (arm[g]) st <= SLOT_ARMED;
               SLOT_ARMED: if (rx_done[g]) st <= SLOT_FULL;
               SLOT_FULL:  if (pop_ok && (q0 == 1'(g))) st <= SLOT_IDLE;
               default:    st <= SLOT_IDLE;
            endcase
         end
      end
   end

   assign slot_state_0 = st_v[0];
   assign slot_state_1 = st_v[1];

   // Pop first, then pushes in slot order; a slot is never queued twice
   always_comb begin
      fcnt_nx = fcnt;
      q0_nx   = q0;
      q1_nx   = q1;
      if (pop_ok) begin
         q0_nx   = q1;
         fcnt_nx = fcnt - 2'd1;
      end
      if (push[0]) begin
         if (fcnt_nx == 2'd0) q0_nx = 1'b0;
         else                 q1_nx = 1'b0;
         fcnt_nx = fcnt_nx + 2'd1;
      end
      if (push[1]) begin
         if (fcnt_nx == 2'd0) q0_nx = 1'b1;
         else                 q1_nx = 1'b1;
         fcnt_nx = fcnt_nx + 2'd1;
      end
   end

   assign avail_nx    = (fcnt_nx != 2'd0);
   assign len_head_nx = q0_nx ? len_nx[1] : len_nx[0];

   // TX control terms shared by the FSM and the irq register
   tx_t              tst;
   logic [TMR_W-1:0] timer;
   logic             tx_irq;
   logic             tx_accept;
   logic             tx_expire;
   logic             tx_irq_nx;

   assign tx_accept = (tst == TX_IDLE) & tx_req & (tx_len != '0);
   assign tx_expire = (tst == TX_WAIT) & (timer == TMR_W'(TX_TIMEOUT - 16'd1));
   assign tx_irq_nx = ((tst == TX_WAIT) & (tx_done | tx_expire)) ? 1'b1 :
                      tx_accept ? 1'b0 : tx_irq;

   always_ff @(posedge sys_clk or posedge sys_rst) begin
      if (sys_rst) begin
         fcnt     <= '0;
         q0       <= 1'b0;
         q1       <= 1'b0;
         rx_avail <= 1'b0;
         rx_slot  <= 1'b0;
         rx_len   <= '0;
         rx_ready <= '0;
         rx_err   <= 1'b0;
         irq      <= 1'b0;
      end else begin
         fcnt     <= fcnt_nx;
         q0       <= q0_nx;
         q1       <= q1_nx;
         rx_avail <= avail_nx;
         rx_slot  <= avail_nx ? q0_nx : 1'b0;
         rx_len   <= avail_nx ? len_head_nx : '0;
         rx_ready <= arm & idle;
         rx_err   <= (|(arm & ~idle)) | (|(rx_done & ~armed));
         irq      <= avail_nx | tx_irq_nx;
      end
   end

   // TX handshake FSM; tx_done takes priority over the timeout
   always_ff @(posedge sys_clk or posedge sys_rst) begin
      if (sys_rst) begin
         tst        <= TX_IDLE;
         timer      <= '0;
         tx_count   <= '0;
         tx_start   <= 1'b0;
         tx_busy    <= 1'b0;
         tx_timeout <= 1'b0;
         tx_irq     <= 1'b0;
      end else begin
         tx_start   <= 1'b0;
         tx_timeout <= 1'b0;
         tx_irq     <= tx_irq_nx;
         case (tst)
            TX_IDLE: begin
               tx_busy <= 1'b0;
               if (tx_accept) begin
                  tx_count <= tx_len;
                  tx_start <= 1'b1;
                  tx_busy  <= 1'b1;
                  tst      <= TX_START;
               end
            end
            TX_START: begin
               timer <= '0;
               tst   <= TX_WAIT;
            end
            TX_WAIT: begin
               if (tx_done) begin
                  tx_busy <= 1'b0;
                  tst     <= TX_IDLE;
               end else if (tx_expire) begin
                  tx_timeout <= 1'b1;
                  tx_busy    <= 1'b0;
                  tst        <= TX_IDLE;
               end else begin
                  timer <= timer + TMR_W'(1);
               end
            end
            default: begin
               tx_busy <= 1'b0;
               tst     <= TX_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_minimac3_slotctl.sv
// Scoreboard bench for minimac3_slotctl: stimulus queues expected pulses and
// queue heads, a negedge monitor pops and compares them as the DUT emits them.
module tb_minimac3_slotctl;

   logic        sys_clk = 1'b0;
   logic        sys_rst = 1'b1;
   logic [1:0]  arm = '0;
   logic [1:0]  rx_done = '0;
   logic [10:0] rx_count_0 = '0;
   logic [10:0] rx_count_1 = '0;
   logic        rx_pop = 1'b0;
   logic        tx_req = 1'b0;
   logic [10:0] tx_len = '0;
   logic        tx_done = 1'b0;

   logic [1:0]  rx_ready;
   logic        rx_avail;
   logic        rx_slot;
   logic [10:0] rx_len;
   logic [1:0]  slot_state_0;
   logic [1:0]  slot_state_1;
   logic        rx_err;
   logic        tx_start;
   logic [10:0] tx_count;
   logic        tx_busy;
   logic        tx_timeout;
   logic        irq;

   logic        tx_req_b = 1'b0;
   logic [10:0] tx_len_b = '0;
   logic [1:0]  rx_ready_b;
   logic        rx_avail_b;
   logic        rx_slot_b;
   logic [10:0] rx_len_b;
   logic [1:0]  slot_state_0_b;
   logic [1:0]  slot_state_1_b;
   logic        rx_err_b;
   logic        tx_start_b;
   logic [10:0] tx_count_b;
   logic        tx_busy_b;
   logic        tx_timeout_b;
   logic        irq_b;

   always #5 sys_clk = ~sys_clk;

   minimac3_slotctl dut (
      .sys_clk(sys_clk), .sys_rst(sys_rst), .arm(arm), .rx_ready(rx_ready),
      .rx_done(rx_done), .rx_count_0(rx_count_0), .rx_count_1(rx_count_1),
      .rx_avail(rx_avail), .rx_slot(rx_slot), .rx_len(rx_len), .rx_pop(rx_pop),
      .slot_state_0(slot_state_0), .slot_state_1(slot_state_1), .rx_err(rx_err),
      .tx_req(tx_req), .tx_len(tx_len), .tx_start(tx_start), .tx_count(tx_count),
      .tx_done(tx_done), .tx_busy(tx_busy), .tx_timeout(tx_timeout), .irq(irq)
   );

   minimac3_slotctl #(.TX_TIMEOUT(16'd8)) dut_to (
      .sys_clk(sys_clk), .sys_rst(sys_rst), .arm(2'b00), .rx_ready(rx_ready_b),
      .rx_done(2'b00), .rx_count_0(11'd0), .rx_count_1(11'd0),
      .rx_avail(rx_avail_b), .rx_slot(rx_slot_b), .rx_len(rx_len_b), .rx_pop(1'b0),
      .slot_state_0(slot_state_0_b), .slot_state_1(slot_state_1_b), .rx_err(rx_err_b),
      .tx_req(tx_req_b), .tx_len(tx_len_b), .tx_start(tx_start_b), .tx_count(tx_count_b),
      .tx_done(1'b0), .tx_busy(tx_busy_b), .tx_timeout(tx_timeout_b), .irq(irq_b)
   );

   int errors = 0;
   int checks = 0;

   logic [1:0]  q_ready[$];
   logic [11:0] q_head[$];
   logic [10:0] q_tx[$];
   int          q_err[$];
   logic        prev_avail = 1'b0;
   logic [11:0] prev_head = '0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   task automatic cyc();
      @(posedge sys_clk);
      #1;
   endtask

   // Monitor: every emitted pulse or new queue head must match the next expectation
   always @(negedge sys_clk) begin
      if (!sys_rst) begin
         if (rx_ready != 2'b00) begin
            if (q_ready.size() == 0) chk("rx_ready_unexpected", 64'(rx_ready), 64'd0);
            else chk("rx_ready", 64'(rx_ready), 64'(q_ready.pop_front()));
         end
         if (rx_err) begin
            checks++;
            if (q_err.size() == 0) begin
               errors++;
               $display("FAIL rx_err_unexpected: got 1 expected 0");
            end else begin
               void'(q_err.pop_front());
            end
         end
         if (rx_avail && (!prev_avail || {rx_slot, rx_len} != prev_head)) begin
            if (q_head.size() == 0) chk("rx_head_unexpected", 64'({rx_slot, rx_len}), 64'hFFF);
            else chk("rx_head(slot,len)", 64'({rx_slot, rx_len}), 64'(q_head.pop_front()));
         end
         if (tx_start) begin
            if (q_tx.size() == 0) chk("tx_start_unexpected", 64'(tx_count), 64'hFFFF);
            else chk("tx_start_count", 64'(tx_count), 64'(q_tx.pop_front()));
         end
      end
      prev_avail = rx_avail;
      prev_head  = {rx_slot, rx_len};
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int n;
      // Reset state
      repeat (2) cyc();
      chk("rst_rx_outs", 64'({rx_ready, rx_avail, rx_slot, rx_len, slot_state_0, slot_state_1, rx_err}), 64'd0);
      chk("rst_tx_outs", 64'({tx_start, tx_count, tx_busy, tx_timeout, irq}), 64'd0);
      sys_rst = 1'b0;
      cyc();

      // Single slot arm/done/pop
      arm = 2'b01; q_ready.push_back(2'b01); cyc(); arm = 2'b00;
      chk("t1_state0_armed", 64'(slot_state_0), 64'd1);
      rx_done = 2'b01; rx_count_0 = 11'd64; q_head.push_back({1'b0, 11'd64}); cyc(); rx_done = 2'b00;
      chk("t1_avail", 64'(rx_avail), 64'd1);
      chk("t1_irq", 64'(irq), 64'd1);
      chk("t1_state0_full", 64'(slot_state_0), 64'd2);
      rx_pop = 1'b1; cyc(); rx_pop = 1'b0;
      chk("t1_avail_after_pop", 64'(rx_avail), 64'd0);
      chk("t1_state0_idle", 64'(slot_state_0), 64'd0);
      chk("t1_irq_clear", 64'(irq), 64'd0);

      // Simultaneous completion: slot 0 ahead of slot 1
      arm = 2'b11; q_ready.push_back(2'b11); cyc(); arm = 2'b00;
      rx_done = 2'b11; rx_count_0 = 11'd100; rx_count_1 = 11'd200;
      q_head.push_back({1'b0, 11'd100}); cyc(); rx_done = 2'b00;
      chk("t2_states_full", 64'({slot_state_1, slot_state_0}), 64'b1010);
      q_head.push_back({1'b1, 11'd200});
      rx_pop = 1'b1; cyc(); rx_pop = 1'b0;
      chk("t2_states_after_pop1", 64'({slot_state_1, slot_state_0}), 64'b1000);
      rx_pop = 1'b1; cyc(); rx_pop = 1'b0;
      chk("t2_avail_empty", 64'(rx_avail), 64'd0);
      chk("t2_states_idle", 64'({slot_state_1, slot_state_0}), 64'd0);

      // Illegal arm, spurious done, arm racing a pop, empty pop
      arm = 2'b01; q_ready.push_back(2'b01); cyc(); arm = 2'b00;
      rx_done = 2'b01; rx_count_0 = 11'd300; q_head.push_back({1'b0, 11'd300}); cyc(); rx_done = 2'b00;
      arm = 2'b01; q_err.push_back(1); cyc(); arm = 2'b00;
      chk("t3_state0_still_full", 64'(slot_state_0), 64'd2);
      rx_done = 2'b10; q_err.push_back(1); cyc(); rx_done = 2'b00;
      chk("t3_head_unchanged", 64'({rx_avail, rx_slot, rx_len}), 64'({1'b1, 1'b0, 11'd300}));
      chk("t3_state1_idle", 64'(slot_state_1), 64'd0);
      arm = 2'b01; rx_pop = 1'b1; q_err.push_back(1); cyc(); arm = 2'b00; rx_pop = 1'b0;
      chk("t3_arm_pop_state0", 64'(slot_state_0), 64'd0);
      chk("t3_arm_pop_avail", 64'(rx_avail), 64'd0);
      rx_pop = 1'b1; cyc(); rx_pop = 1'b0;
      chk("t3_empty_pop", 64'({rx_avail, slot_state_1, slot_state_0}), 64'd0);

      // Push and pop in the same cycle
      arm = 2'b11; q_ready.push_back(2'b11); cyc(); arm = 2'b00;
      rx_done = 2'b01; rx_count_0 = 11'd10; q_head.push_back({1'b0, 11'd10}); cyc(); rx_done = 2'b00;
      rx_done = 2'b10; rx_count_1 = 11'd20; rx_pop = 1'b1; q_head.push_back({1'b1, 11'd20});
      cyc(); rx_done = 2'b00; rx_pop = 1'b0;
      chk("t4_pushpop_avail", 64'({rx_avail, rx_len}), 64'({1'b1, 11'd20}));
      chk("t4_pushpop_states", 64'({slot_state_1, slot_state_0}), 64'b1000);
      rx_pop = 1'b1; cyc(); rx_pop = 1'b0;
      chk("t4_drained", 64'({rx_avail, slot_state_1}), 64'd0);

      // TX request, busy-time request ignored, done after 10 cycles
      tx_len = 11'd1514; tx_req = 1'b1; q_tx.push_back(11'd1514); cyc(); tx_req = 1'b0;
      chk("t5_busy_start", 64'(tx_busy), 64'd1);
      cyc();
      chk("t5_busy_wait", 64'({tx_start, tx_busy}), 64'b01);
      tx_len = 11'd99; tx_req = 1'b1; cyc(); tx_req = 1'b0;
      repeat (7) cyc();
      tx_done = 1'b1; cyc(); tx_done = 1'b0;
      chk("t5_done_busy", 64'(tx_busy), 64'd0);
      chk("t5_done_irq", 64'(irq), 64'd1);
      chk("t5_count_held", 64'(tx_count), 64'd1514);
      tx_done = 1'b1; cyc(); tx_done = 1'b0;
      chk("t5_idle_done_ignored", 64'({tx_busy, irq}), 64'b01);
      tx_len = 11'd60; tx_req = 1'b1; q_tx.push_back(11'd60); cyc(); tx_req = 1'b0;
      chk("t5_req2_irq_clear", 64'(irq), 64'd0);
      chk("t5_req2_count", 64'(tx_count), 64'd60);
      tx_done = 1'b1; cyc(); tx_done = 1'b0;
      chk("t5_start_done_ignored", 64'(tx_busy), 64'd1);
      tx_done = 1'b1; cyc(); tx_done = 1'b0;
      chk("t5_req2_finish", 64'({tx_busy, irq}), 64'b01);

      // Timeout instance: zero-length request ignored, then timeout after 8 WAIT cycles
      tx_len_b = 11'd0; tx_req_b = 1'b1; cyc(); tx_req_b = 1'b0;
      chk("t6_zero_len_start", 64'({tx_start_b, tx_busy_b}), 64'd0);
      cyc();
      chk("t6_zero_len_later", 64'(tx_start_b), 64'd0);
      tx_len_b = 11'd5; tx_req_b = 1'b1; cyc(); tx_req_b = 1'b0;
      chk("t6_start", 64'(tx_start_b), 64'd1);
      cyc();
      n = 0;
      while (n < 20) begin
         cyc();
         n++;
         if (tx_timeout_b) break;
      end
      chk("t6_timeout_cycles", 64'(n), 64'd8);
      chk("t6_after_timeout", 64'({tx_busy_b, irq_b}), 64'b01);
      cyc();
      chk("t6_timeout_pulse_width", 64'(tx_timeout_b), 64'd0);

      // Reset during WAIT with slot 1 FULL
      arm = 2'b10; q_ready.push_back(2'b10); cyc(); arm = 2'b00;
      rx_done = 2'b10; rx_count_1 = 11'd77; q_head.push_back({1'b1, 11'd77}); cyc(); rx_done = 2'b00;
      tx_len = 11'd40; tx_req = 1'b1; q_tx.push_back(11'd40); cyc(); tx_req = 1'b0;
      cyc();
      chk("t7_pre_rst", 64'({tx_busy, slot_state_1}), 64'b110);
      #2 sys_rst = 1'b1;
      #1;
      chk("t7_rst_rx_outs", 64'({rx_ready, rx_avail, rx_slot, rx_len, slot_state_0, slot_state_1, rx_err}), 64'd0);
      chk("t7_rst_tx_outs", 64'({tx_start, tx_count, tx_busy, tx_timeout, irq}), 64'd0);
      cyc();
      sys_rst = 1'b0;
      tx_done = 1'b1; cyc(); tx_done = 1'b0;
      chk("t7_late_tx_done", 64'({tx_start, tx_busy, irq}), 64'd0);
      rx_done = 2'b10; q_err.push_back(1); cyc(); rx_done = 2'b00;
      chk("t7_late_rx_done", 64'({rx_avail, slot_state_1}), 64'd0);
      cyc();

      chk("leftover_ready", 64'(q_ready.size()), 64'd0);
      chk("leftover_head", 64'(q_head.size()), 64'd0);
      chk("leftover_tx", 64'(q_tx.size()), 64'd0);
      chk("leftover_err", 64'(q_err.size()), 64'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
